// File: rtl/serial_7seg_shifter.sv
// serial_7seg_shifter: shifts a snapshot of all digit patterns MSB-first into a
// 74HC595-style chain, then pulses the storage latch so the display updates at once.
// Ports: clock, reset (sync, active high), start, digit_data in;
//        busy, done, ser_clk, ser_data, ser_latch out (all registered).
module serial_7seg_shifter #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_BITS   = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_DIGITS*SEG_BITS-1:0] digit_data,
  output logic                           busy,
  output logic                           done,
  output logic                           ser_clk,
  output logic                           ser_data,
  output logic                           ser_latch
);

  localparam int TOTAL = NUM_DIGITS * SEG_BITS;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int DW    = $clog2(CLK_DIV + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [TOTAL-1:0] frame, frame_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [DW-1:0]    div, div_n;
  logic             pending, pending_n;
  logic             div_end;

  assign div_end = (div == DIV_LAST);

  always_comb begin
    state_n   = state;
    frame_n   = frame;
    bit_cnt_n = bit_cnt;
    div_n     = div + DW'(1);
    pending_n = pending;
    // Requests arriving mid-frame collapse into a single follow-up frame.
    if (start && state != IDLE) pending_n = 1'b1;
    unique case (state)
      IDLE: begin
        div_n = '0;
        if (start) begin
          frame_n   = digit_data;
          bit_cnt_n = '0;
          state_n   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_end) begin
          div_n   = '0;
          state_n = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (div_end) begin
          div_n = '0;
          if (bit_cnt == BIT_LAST) begin
            state_n = LATCH;
          end else begin
            frame_n   = {frame[TOTAL-2:0], 1'b0};
            bit_cnt_n = bit_cnt + BW'(1);
            state_n   = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (div_end) begin
          div_n   = '0;
          state_n = DONE;
        end
      end
      DONE: begin
        div_n     = '0;
        pending_n = 1'b0;
        // The follow-up frame takes the data present now, not at request time.
        if (pending || start) begin
          frame_n   = digit_data;
          bit_cnt_n = '0;
          state_n   = SHIFT_LO;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        div_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      frame     <= '0;
      bit_cnt   <= '0;
      div       <= '0;
      pending   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ser_clk   <= 1'b0;
      ser_data  <= 1'b0;
      ser_latch <= 1'b0;
    end else begin
      state     <= state_n;
      frame     <= frame_n;
      bit_cnt   <= bit_cnt_n;
      div       <= div_n;
      pending   <= pending_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      ser_clk   <= (state_n == SHIFT_HI);
      ser_latch <= (state_n == LATCH);
      ser_data  <= ((state_n == SHIFT_LO) || (state_n == SHIFT_HI))
                   && frame_n[TOTAL-1];
    end
  end

endmodule
